// File: rtl/serial_reg_responder.sv
// serial_reg_responder: bit-serial write/read frame decoder owning a small register bank
module serial_reg_responder #(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdi,
  output logic                 sdo,
  output logic                 sdo_oe,
  output logic                 busy,
  output logic                 wr_strobe,
  output logic                 err,
  output logic [NREG*DW-1:0]   regs
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, STOP, TURN, RDATA} state_t;
  state_t state_q, state_d;
  logic rw_q, rw_d;
  logic [2:0] addr_q, addr_d;
  logic [5:0] cnt_q, cnt_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [NREG*DW-1:0] regs_q, regs_d;
  logic sdo_q, sdo_d, oe_q, oe_d, busy_q, busy_d, wr_q, wr_d, err_q, err_d;
  logic addr_ok;
  assign addr_ok = {1'b0, addr_q} < 4'(NREG);
  // next-state, shift/counter and registered-output logic for the frame FSM
  always_comb begin
    state_d = state_q;
    rw_d = rw_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    regs_d = regs_q;
    sdo_d = 1'b0;
    oe_d = 1'b0;
    wr_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: state_d = sdi ? IDLE : CMD;
      CMD: begin
        rw_d = sdi;
        cnt_d = '0;
        state_d = ADDR;
      end
      ADDR: begin
        addr_d = {addr_q[1:0], sdi};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd2) begin
          cnt_d = '0;
          state_d = rw_q ? WDATA : TURN;
          if (!rw_q) begin
            sh_d = '0;
            for (int k = 0; k < NREG; k++)
              if (3'(k) == addr_d) sh_d = regs_q[k*DW +: DW];
          end
        end
      end
      WDATA: begin
        sh_d = DW'({sh_q, sdi});
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'(DW - 1)) ? STOP : WDATA;
      end
      STOP: begin
        state_d = IDLE;
        wr_d = sdi && addr_ok;
        err_d = !(sdi && addr_ok);
        for (int k = 0; k < NREG; k++)
          if (wr_d && 3'(k) == addr_q) regs_d[k*DW +: DW] = sh_q;
      end
      TURN: begin
        state_d = RDATA;
        err_d = !addr_ok;
        sdo_d = sh_q[DW-1];
        oe_d = 1'b1;
        sh_d = sh_q << 1;
        cnt_d = 6'd1;
      end
      RDATA: begin
        state_d = (cnt_q == 6'(DW)) ? IDLE : RDATA;
        oe_d = cnt_q != 6'(DW);
        sdo_d = oe_d & sh_q[DW-1];
        sh_d = oe_d ? sh_q << 1 : sh_q;
        cnt_d = oe_d ? cnt_q + 6'd1 : cnt_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rw_q <= 1'b0;
      addr_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      regs_q <= '0;
      sdo_q <= 1'b0;
      oe_q <= 1'b0;
      busy_q <= 1'b0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      regs_q <= regs_d;
      sdo_q <= sdo_d;
      oe_q <= oe_d;
      busy_q <= busy_d;
      wr_q <= wr_d;
      err_q <= err_d;
    end
  end
  assign sdo = sdo_q;
  assign sdo_oe = oe_q;
  assign busy = busy_q;
  assign wr_strobe = wr_q;
  assign err = err_q;
  assign regs = regs_q;
endmodule
